// File: rtl/ex_mult_div.sv
// EX-stage multiply/divide unit: registered MULT/MULTU and a radix-2 restoring DIV/DIVU.
// Holds the pipeline through stall_request until done pulses with fresh hi_out/lo_out.
module ex_mult_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [5:0]            funct,
   input  logic [DATA_WIDTH-1:0] operand_1,
   input  logic [DATA_WIDTH-1:0] operand_2,
   input  logic                  flush,
   output logic                  stall_request,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi_out,
   output logic [DATA_WIDTH-1:0] lo_out
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state, state_nx;
   logic [W-1:0]   op_a, op_b;
   logic           op_signed;
   logic [W-1:0]   rem, quo;
   logic [CW-1:0]  cnt;
   logic           neg_q, neg_r;

   logic           funct_valid, funct_div, funct_signed, accept;
   logic [W-1:0]   mag_1, mag_2;
   logic [2*W-1:0] ext_a, ext_b, product;
   logic [W:0]     shifted, diff;
   logic           borrow;
   logic [W-1:0]   rem_nx, quo_nx, q_final, r_final;

   // Handshake: start with a valid funct in IDLE is accepted unless flush is high;
   // the op is consumed when done pulses, and stall_request holds EX until then.
   always_comb begin
      funct_valid  = (funct[5:2] == 4'b0110);
      funct_div    = funct[1];
      funct_signed = ~funct[0];
      accept       = (state == S_IDLE) && start && funct_valid && !flush;
      mag_1 = (funct_signed && operand_1[W-1]) ? -operand_1 : operand_1;
      mag_2 = (funct_signed && operand_2[W-1]) ? -operand_2 : operand_2;
   end

   // Sign- or zero-extend to 2W so one unsigned multiply covers both MULT and MULTU.
   always_comb begin
      ext_a   = {{W{op_signed & op_a[W-1]}}, op_a};
      ext_b   = {{W{op_signed & op_b[W-1]}}, op_b};
      product = ext_a * ext_b;
   end

   // One restoring step; the partial remainder is always below the divisor, so W+1 bits hold it.
   always_comb begin
      shifted = {rem, quo[W-1]};
      diff    = shifted - {1'b0, op_b};
      borrow  = diff[W];
      rem_nx  = borrow ? shifted[W-1:0] : diff[W-1:0];
      quo_nx  = {quo[W-2:0], ~borrow};
      q_final = neg_q ? -quo_nx : quo_nx;
      r_final = neg_r ? -rem_nx : rem_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (funct_div && operand_2 == '0) state_nx = S_DONE;
                  else if (funct_div)               state_nx = S_DIV;
                  else                              state_nx = S_MUL;
               end
            end
            S_MUL:   state_nx = S_DONE;
            S_DIV:   if (cnt == CNT_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      stall_request = accept || (state == S_MUL) || (state == S_DIV);
      done          = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // hi_out/lo_out are written on the edge into DONE so they are valid while done is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_a      <= '0;
         op_b      <= '0;
         op_signed <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         hi_out    <= '0;
         lo_out    <= '0;
      end else if (!flush) begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_a      <= operand_1;
                  op_b      <= funct_div ? mag_2 : operand_2;
                  op_signed <= funct_signed;
                  rem       <= '0;
                  quo       <= mag_1;
                  cnt       <= '0;
                  neg_q     <= funct_signed & (operand_1[W-1] ^ operand_2[W-1]);
                  neg_r     <= funct_signed & operand_1[W-1];
                  if (funct_div && operand_2 == '0) begin
                     hi_out <= operand_1;
                     lo_out <= '1;
                  end
               end
            end
            S_MUL: begin
               hi_out <= product[2*W-1:W];
               lo_out <= product[W-1:0];
            end
            S_DIV: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  hi_out <= r_final;
                  lo_out <= q_final;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mult_div.sv
// Directed bench for ex_mult_div: driver tasks push expected {hi,lo} into a queue,
// a monitor pops and compares on every done pulse.
module tb_ex_mult_div;

   localparam int W = 32;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic         clk;
   logic         rst;
   logic         start;
   logic [5:0]   funct;
   logic [W-1:0] operand_1, operand_2;
   logic         flush;
   logic         stall_request, done;
   logic [W-1:0] hi_out, lo_out;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_res;
   int checks = 0;
   int errors = 0;
   logic prev_done = 1'b0;

   ex_mult_div #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct),
      .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
      .stall_request(stall_request), .done(done), .hi_out(hi_out), .lo_out(lo_out)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin
               logic [2*W-1:0] e;
               e = exp_q.pop_front();
               check("result_hi_lo", {hi_out, lo_out}, e);
               last_res = e;
            end
            check("done_not_back_to_back", {63'd0, prev_done}, 64'd0);
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // driver: issue one op, check latency and stall length
   task automatic run_op(input string name, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input int exp_lat);
      int lat;
      int stall_cnt;
      @(negedge clk);
      start = 1'b1; funct = f; operand_1 = a; operand_2 = b;
      exp_q.push_back({eh, el});
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      stall_cnt = 1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            check({name, "_stall_low_at_done"}, {63'd0, stall_request}, 64'd0);
            break;
         end
         if (stall_request) stall_cnt++;
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
   endtask

   initial begin
      int gap;
      int dcount;
      rst = 1'b0; start = 1'b0; funct = 6'h0; operand_1 = '0; operand_2 = '0; flush = 1'b0;
      last_res = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // reset state held with start low
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_idle", {hi_out, lo_out}, 64'd0);
         check("reset_ctrl", {62'd0, done, stall_request}, 64'd0);
      end

      run_op("mult",  F_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2);
      run_op("multu", F_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 2);
      run_op("div",   F_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
      run_op("divu",  F_DIVU,  32'd100,      32'd7, 32'd2,        32'd14,       33);
      run_op("divu0", F_DIVU,  32'h1234,     32'd0, 32'h1234,     32'hFFFFFFFF, 1);
      run_op("divov", F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
      run_op("div0s", F_DIV,   32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1);
      run_op("divneg", F_DIV,  32'd100,      32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 33);

      // back-to-back: MULT 5*-4 then DIVU 1000/33 with start held
      @(negedge clk);
      start = 1'b1; funct = F_MULT; operand_1 = 32'd5; operand_2 = 32'hFFFFFFFC;
      exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEC});
      exp_q.push_back({32'd10, 32'd30});
      @(posedge clk);
      #1 funct = F_DIVU; operand_1 = 32'd1000; operand_2 = 32'd33;
      dcount = 0;
      for (int i = 0; i < 5 && !done; i++) @(negedge clk);
      check("b2b_first_done", {63'd0, done}, 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      gap = 1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done) begin
            dcount = 1;
            break;
         end
         gap++;
      end
      check("b2b_second_done", 64'(dcount), 64'd1);
      check("b2b_gap", 64'(gap), 64'd33);
      repeat (40) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("b2b_no_duplicate", 64'(dcount), 64'd1);

      // flush at DIV iteration 10
      @(negedge clk);
      start = 1'b1; funct = F_DIVU; operand_1 = 32'd1000; operand_2 = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_stall_low", {62'd0, done, stall_request}, 64'd0);
      check("flush_hold_hi_lo", {hi_out, lo_out}, {32'd10, 32'd30});
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("flush_no_done", 64'(dcount), 64'd0);

      // flush in IDLE with start: nothing accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct = F_MULT; operand_1 = 32'd7; operand_2 = 32'd7;
      #1 check("flush_idle_no_stall", {63'd0, stall_request}, 64'd0);
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      dcount = 0;
      repeat (5) begin
         @(negedge clk);
         if (done || stall_request) dcount++;
      end
      check("flush_idle_no_accept", 64'(dcount), 64'd0);

      // asynchronous reset mid-DIV
      @(negedge clk);
      start = 1'b1; funct = F_DIV; operand_1 = 32'd12345; operand_2 = 32'd11;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b0;
      #1 check("async_reset_hi_lo", {hi_out, lo_out}, 64'd0);
      check("async_reset_ctrl", {62'd0, done, stall_request}, 64'd0);
      @(negedge clk) rst = 1'b1;
      run_op("post_reset_divu", F_DIVU, 32'd81, 32'd9, 32'd0, 32'd9, 33);

      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
